mem_port_arbiter: RTL and testbench

Shares the CPU's single memory port between the fetch stage's instruction bus and the memory stage's data bus. The block latches one requester's transaction, drives it downstream, and routes the address and data acknowledgements back to the winning requester. Only one transaction is in flight at a time. Data requests take priority over instruction requests, and a streak limit guarantees fetch forward progress.

---
 rtl/mem_port_arbiter_pkg.sv | 41 ++++
 rtl/mem_port_arbiter_streak.sv | 49 ++++
 rtl/mem_port_arbiter.sv | 168 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory-port arbiter.
// Holds the FSM state and owner encodings and the downstream request bundle.
// The bundle is used both for the request latch and for the m_* outputs.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } arb_owner_t;

    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [3:0]  strobe;
        logic [31:0] wdata;
    } mem_req_t;

    // Streak counter width and its saturation value.
    localparam int unsigned STREAK_W   = 4;
    localparam logic [3:0]  STREAK_SAT = 4'd15;

    // Request bundle that goes downstream whenever no request is being presented.
    localparam mem_req_t MEM_REQ_NONE = '{addr: 32'h0, write: 1'b0, strobe: 4'b0000, wdata: 32'h0};

    // Fetches are always reads with no byte enables.
    function automatic mem_req_t fetch_req(input logic [31:0] addr);
        mem_req_t req;
        req.addr   = addr;
        req.write  = 1'b0;
        req.strobe = 4'b0000;
        req.wdata  = 32'h0;
        return req;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_streak.sv
// arb_streak_counter: counts consecutive data-bus grants made while a fetch
// is waiting, and flags starvation once the count reaches MAX_D_STREAK.
// Ports:
//   clk, reset  - clock, asynchronous active-high reset
//   i_pending   - fetch request currently asserted
//   grant_d     - data bus granted this cycle
//   grant_i     - instruction bus granted this cycle
//   starve      - fetch has waited through MAX_D_STREAK data grants
module arb_streak_counter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned MAX_D_STREAK = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic i_pending,
    input  logic grant_d,
    input  logic grant_i,
    output logic starve
);

    localparam logic [STREAK_W-1:0] STREAK_LIMIT = STREAK_W'(MAX_D_STREAK);

    logic [STREAK_W-1:0] streak_r;

    // Saturating count of data grants taken while a fetch was pending.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            streak_r <= 4'd0;
        end else if (grant_d) begin
            if (i_pending) begin
                if (streak_r != STREAK_SAT) begin
                    streak_r <= streak_r + 4'd1;
                end
            end else begin
                // Nobody was starved by this grant, so the streak restarts.
                streak_r <= 4'd0;
            end
        end else if (grant_i) begin
            streak_r <= 4'd0;
        end
    end

    // Starvation only matters while a fetch is actually waiting.
    always_comb begin
        starve = i_pending && (streak_r == STREAK_LIMIT);
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one downstream memory port between the fetch
// (i_*) and data (d_*) buses. One transaction in flight at a time; data has
// priority, bounded by a streak limit so fetches always make progress.
// Ports:
//   clk, reset           - clock, asynchronous active-high reset
//   i_valid/i_addr       - fetch request;  i_addr_ok/i_data_ok/i_rdata back
//   d_valid/d_addr/d_write/d_strobe/d_wdata - data request;
//                          d_addr_ok/d_data_ok/d_rdata back
//   m_valid/m_addr/m_write/m_strobe/m_wdata - downstream request
//   m_ready/m_rvalid/m_rdata                - downstream handshake/response
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned MAX_D_STREAK = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_valid,
    input  logic [31:0] i_addr,
    output logic        i_addr_ok,
    output logic        i_data_ok,
    output logic [31:0] i_rdata,
    input  logic        d_valid,
    input  logic [31:0] d_addr,
    input  logic        d_write,
    input  logic [3:0]  d_strobe,
    input  logic [31:0] d_wdata,
    output logic        d_addr_ok,
    output logic        d_data_ok,
    output logic [31:0] d_rdata,
    output logic        m_valid,
    output logic [31:0] m_addr,
    output logic        m_write,
    output logic [3:0]  m_strobe,
    output logic [31:0] m_wdata,
    input  logic        m_ready,
    input  logic        m_rvalid,
    input  logic [31:0] m_rdata
);

    arb_state_t state_r;
    arb_state_t state_s;
    arb_owner_t owner_r;
    mem_req_t   req_r;
    mem_req_t   req_out_s;

    logic grant_d_s;
    logic grant_i_s;
    logic starve_s;
    logic addr_ok_s;
    logic data_ok_s;

    arb_streak_counter #(
        .MAX_D_STREAK (MAX_D_STREAK)
    ) u_streak (
        .clk       (clk),
        .reset     (reset),
        .i_pending (i_valid),
        .grant_d   (grant_d_s),
        .grant_i   (grant_i_s),
        .starve    (starve_s)
    );

    // Grant decision in IDLE: data first unless the fetch side is starving.
    always_comb begin
        grant_d_s = 1'b0;
        grant_i_s = 1'b0;
        if (state_r == IDLE) begin
            if (d_valid && !starve_s) begin
                grant_d_s = 1'b1;
            end else if (i_valid) begin
                grant_i_s = 1'b1;
            end else begin
                grant_i_s = 1'b0;
            end
        end else begin
            grant_d_s = 1'b0;
        end
    end

    // Address and data acknowledgements; ready and rvalid may coincide in REQ.
    always_comb begin
        addr_ok_s = (state_r == REQ) && m_ready;
        data_ok_s = m_rvalid && ((state_r == RESP) || addr_ok_s);
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (grant_d_s || grant_i_s) begin
                    state_s = REQ;
                end else begin
                    state_s = IDLE;
                end
            end
            REQ: begin
                if (m_ready && m_rvalid) begin
                    state_s = IDLE;
                end else if (m_ready) begin
                    state_s = RESP;
                end else begin
                    state_s = REQ;
                end
            end
            RESP: begin
                if (m_rvalid) begin
                    state_s = IDLE;
                end else begin
                    state_s = RESP;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, owner and request latch; the latch only loads on a grant.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            owner_r <= OWN_I;
            req_r   <= MEM_REQ_NONE;
        end else begin
            state_r <= state_s;
            if (grant_d_s) begin
                owner_r <= OWN_D;
                req_r   <= '{addr: d_addr, write: d_write, strobe: d_strobe, wdata: d_wdata};
            end else if (grant_i_s) begin
                owner_r <= OWN_I;
                req_r   <= fetch_req(i_addr);
            end
        end
    end

    // Downstream bundle is presented only in REQ so nothing is asserted otherwise.
    always_comb begin
        if (state_r == REQ) begin
            req_out_s = req_r;
        end else begin
            req_out_s = MEM_REQ_NONE;
        end
    end

    // Outputs: acks steered to the owner; read data quieted while idle so
    // stale responses and reset leave every output at zero.
    always_comb begin
        m_valid   = (state_r == REQ);
        m_addr    = req_out_s.addr;
        m_write   = req_out_s.write;
        m_strobe  = req_out_s.strobe;
        m_wdata   = req_out_s.wdata;
        i_addr_ok = addr_ok_s && (owner_r == OWN_I);
        i_data_ok = data_ok_s && (owner_r == OWN_I);
        d_addr_ok = addr_ok_s && (owner_r == OWN_D);
        d_data_ok = data_ok_s && (owner_r == OWN_D);
        if (state_r != IDLE) begin
            i_rdata = m_rdata;
            d_rdata = m_rdata;
        end else begin
            i_rdata = 32'h0;
            d_rdata = 32'h0;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    logic        clk;
    logic        reset;
    logic        i_valid;
    logic [31:0] i_addr;
    logic        i_addr_ok;
    logic        i_data_ok;
    logic [31:0] i_rdata;
    logic        d_valid;
    logic [31:0] d_addr;
    logic        d_write;
    logic [3:0]  d_strobe;
    logic [31:0] d_wdata;
    logic        d_addr_ok;
    logic        d_data_ok;
    logic [31:0] d_rdata;
    logic        m_valid;
    logic [31:0] m_addr;
    logic        m_write;
    logic [3:0]  m_strobe;
    logic [31:0] m_wdata;
    logic        m_ready;
    logic        m_rvalid;
    logic [31:0] m_rdata;

    int n_chk  = 0;
    int n_fail = 0;

    logic [137:0] all_out;
    assign all_out = {m_valid, m_addr, m_write, m_strobe, m_wdata, i_addr_ok, i_data_ok,
                      i_rdata, d_addr_ok, d_data_ok, d_rdata};

    mem_port_arbiter #(.MAX_D_STREAK(4)) dut (
        .clk(clk), .reset(reset),
        .i_valid(i_valid), .i_addr(i_addr), .i_addr_ok(i_addr_ok), .i_data_ok(i_data_ok),
        .i_rdata(i_rdata),
        .d_valid(d_valid), .d_addr(d_addr), .d_write(d_write), .d_strobe(d_strobe),
        .d_wdata(d_wdata), .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok), .d_rdata(d_rdata),
        .m_valid(m_valid), .m_addr(m_addr), .m_write(m_write), .m_strobe(m_strobe),
        .m_wdata(m_wdata), .m_ready(m_ready), .m_rvalid(m_rvalid), .m_rdata(m_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        i_valid = 1'b0; i_addr = 32'h0;
        d_valid = 1'b0; d_addr = 32'h0; d_write = 1'b0; d_strobe = 4'b0000; d_wdata = 32'h0;
        m_ready = 1'b0; m_rvalid = 1'b0; m_rdata = 32'h0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_inputs();
        i_valid = 1'b1; d_valid = 1'b1; m_ready = 1'b1; m_rvalid = 1'b1; m_rdata = 32'hFFFF_FFFF;
        #1;
        n_chk++; if (all_out !== 138'h0) begin n_fail++; $display("FAIL reset_outputs: got %h want 0", all_out); end
        tick();
        n_chk++; if (all_out !== 138'h0) begin n_fail++; $display("FAIL reset_held_outputs: got %h want 0", all_out); end
        clear_inputs();
        #1;
        reset = 1'b0;
        tick();
        n_chk++; if (all_out !== 138'h0) begin n_fail++; $display("FAIL reset_idle_outputs: got %h want 0", all_out); end
    endtask

    task automatic test_single_fetch();
        i_valid = 1'b1; i_addr = 32'hBFC0_0000;
        tick();                                         // cycle 1: REQ
        i_valid = 1'b0; m_ready = 1'b1; #1;
        n_chk++; if (m_valid !== 1'b1 || m_addr !== 32'hBFC0_0000 || m_write !== 1'b0 || m_strobe !== 4'b0000) begin
            n_fail++; $display("FAIL fetch_req: got v=%b a=%h w=%b s=%b want 1 bfc00000 0 0000", m_valid, m_addr, m_write, m_strobe); end
        n_chk++; if (i_addr_ok !== 1'b1 || i_data_ok !== 1'b0 || d_addr_ok !== 1'b0 || d_data_ok !== 1'b0) begin
            n_fail++; $display("FAIL fetch_addr_ok: got ia=%b id=%b da=%b dd=%b want 1 0 0 0", i_addr_ok, i_data_ok, d_addr_ok, d_data_ok); end
        tick();                                         // cycle 2: RESP
        m_ready = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h2408_0001; #1;
        n_chk++; if (i_data_ok !== 1'b1 || i_rdata !== 32'h2408_0001 || d_data_ok !== 1'b0 || m_valid !== 1'b0) begin
            n_fail++; $display("FAIL fetch_data_ok: got id=%b rd=%h dd=%b mv=%b want 1 24080001 0 0", i_data_ok, i_rdata, d_data_ok, m_valid); end
        tick();                                         // cycle 3: IDLE
        m_rvalid = 1'b0; #1;
        n_chk++; if (all_out !== 138'h0) begin n_fail++; $display("FAIL fetch_back_idle: got %h want 0", all_out); end
    endtask

    task automatic test_simultaneous();
        i_valid = 1'b1; i_addr = 32'hBFC0_0004;
        d_valid = 1'b1; d_addr = 32'h8000_0010; d_write = 1'b1; d_strobe = 4'b0011; d_wdata = 32'hDEAD_BEEF;
        tick();                                         // cycle 1: D owns
        d_valid = 1'b0; m_ready = 1'b1; #1;
        n_chk++; if (m_valid !== 1'b1 || m_addr !== 32'h8000_0010 || m_write !== 1'b1 || m_strobe !== 4'b0011 || m_wdata !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL simul_store_req: got v=%b a=%h w=%b s=%b d=%h want 1 80000010 1 0011 deadbeef", m_valid, m_addr, m_write, m_strobe, m_wdata); end
        n_chk++; if (d_addr_ok !== 1'b1 || i_addr_ok !== 1'b0) begin
            n_fail++; $display("FAIL simul_addr_ok: got d=%b i=%b want 1 0", d_addr_ok, i_addr_ok); end
        tick();                                         // cycle 2: RESP
        m_ready = 1'b0; m_rvalid = 1'b1; #1;
        n_chk++; if (d_data_ok !== 1'b1 || i_data_ok !== 1'b0 || m_valid !== 1'b0) begin
            n_fail++; $display("FAIL simul_data_ok: got d=%b i=%b mv=%b want 1 0 0", d_data_ok, i_data_ok, m_valid); end
        tick();                                         // cycle 3: IDLE, fetch still pending
        m_rvalid = 1'b0; #1;
        n_chk++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL simul_idle_gap: got m_valid=%b want 0", m_valid); end
        tick();                                         // cycle 4: I owns
        i_valid = 1'b0; m_ready = 1'b1; m_rvalid = 1'b1; m_rdata = 32'h0000_1111; #1;
        n_chk++; if (m_valid !== 1'b1 || m_addr !== 32'hBFC0_0004 || m_write !== 1'b0 || m_strobe !== 4'b0000 || m_wdata !== 32'h0) begin
            n_fail++; $display("FAIL simul_fetch_req: got v=%b a=%h w=%b s=%b d=%h want 1 bfc00004 0 0000 0", m_valid, m_addr, m_write, m_strobe, m_wdata); end
        n_chk++; if (i_addr_ok !== 1'b1 || i_data_ok !== 1'b1 || d_addr_ok !== 1'b0 || d_data_ok !== 1'b0) begin
            n_fail++; $display("FAIL simul_fetch_ack: got ia=%b id=%b da=%b dd=%b want 1 1 0 0", i_addr_ok, i_data_ok, d_addr_ok, d_data_ok); end
        tick();
        clear_inputs();
    endtask

    task automatic test_stall();
        d_valid = 1'b1; d_addr = 32'h8000_1000; d_write = 1'b0;
        tick();
        d_valid = 1'b0; d_addr = 32'h1234_5678;
        for (int k = 0; k < 5; k++) begin
            #1;
            n_chk++; if (m_valid !== 1'b1 || m_addr !== 32'h8000_1000 || d_addr_ok !== 1'b0) begin
                n_fail++; $display("FAIL stall_hold[%0d]: got v=%b a=%h ok=%b want 1 80001000 0", k, m_valid, m_addr, d_addr_ok); end
            tick();
        end
        m_ready = 1'b1; #1;
        n_chk++; if (m_valid !== 1'b1 || m_addr !== 32'h8000_1000 || d_addr_ok !== 1'b1) begin
            n_fail++; $display("FAIL stall_ready: got v=%b a=%h ok=%b want 1 80001000 1", m_valid, m_addr, d_addr_ok); end
        tick();
        m_ready = 1'b0; m_rvalid = 1'b1; m_rdata = 32'hCAFE_F00D; #1;
        n_chk++; if (d_data_ok !== 1'b1 || d_rdata !== 32'hCAFE_F00D || d_addr_ok !== 1'b0) begin
            n_fail++; $display("FAIL stall_data: got ok=%b rd=%h aok=%b want 1 cafef00d 0", d_data_ok, d_rdata, d_addr_ok); end
        tick();
        clear_inputs(); #1;
        n_chk++; if (all_out !== 138'h0) begin n_fail++; $display("FAIL stall_idle: got %h want 0", all_out); end
    endtask

    task automatic test_same_cycle();
        d_valid = 1'b1; d_addr = 32'h8000_2000; d_write = 1'b0;
        tick();                                         // cycle 1
        d_valid = 1'b0; i_valid = 1'b1; i_addr = 32'hBFC0_0100;
        m_ready = 1'b1; m_rvalid = 1'b1; m_rdata = 32'h1122_3344; #1;
        n_chk++; if (d_addr_ok !== 1'b1 || d_data_ok !== 1'b1 || d_rdata !== 32'h1122_3344 || i_addr_ok !== 1'b0 || i_data_ok !== 1'b0) begin
            n_fail++; $display("FAIL same_cycle_ack: got da=%b dd=%b rd=%h ia=%b id=%b want 1 1 11223344 0 0", d_addr_ok, d_data_ok, d_rdata, i_addr_ok, i_data_ok); end
        tick();                                         // cycle 2: IDLE, grant fetch here
        m_ready = 1'b0; m_rvalid = 1'b0; #1;
        n_chk++; if (m_valid !== 1'b0 || d_data_ok !== 1'b0) begin
            n_fail++; $display("FAIL same_cycle_idle: got mv=%b dd=%b want 0 0", m_valid, d_data_ok); end
        tick();                                         // cycle 3: fetch request out
        i_valid = 1'b0; m_ready = 1'b1; m_rvalid = 1'b1; #1;
        n_chk++; if (m_valid !== 1'b1 || m_addr !== 32'hBFC0_0100 || i_addr_ok !== 1'b1 || i_data_ok !== 1'b1) begin
            n_fail++; $display("FAIL same_cycle_next: got v=%b a=%h ia=%b id=%b want 1 bfc00100 1 1", m_valid, m_addr, i_addr_ok, i_data_ok); end
        tick();
        clear_inputs();
    endtask

    task automatic test_starvation();
        logic [9:0] exp_d;
        exp_d = 10'b0111101111;                          // bit k: grant k is D
        d_valid = 1'b1; d_addr = 32'h0000_1000;
        i_valid = 1'b1; i_addr = 32'h0000_2000;
        for (int k = 0; k < 10; k++) begin
            tick();                                     // grant edge
            m_ready = 1'b1; m_rvalid = 1'b1; #1;
            n_chk++; if (m_valid !== 1'b1 || m_addr !== (exp_d[k] ? 32'h0000_1000 : 32'h0000_2000)) begin
                n_fail++; $display("FAIL starve_order[%0d]: got v=%b a=%h want 1 %h", k, m_valid, m_addr, exp_d[k] ? 32'h0000_1000 : 32'h0000_2000); end
            if (k == 3) begin
                n_chk++; if (dut.u_streak.streak_r !== 4'd4) begin
                    n_fail++; $display("FAIL starve_streak_max: got %0d want 4", dut.u_streak.streak_r); end
            end
            if (k == 4) begin
                n_chk++; if (dut.u_streak.streak_r !== 4'd0) begin
                    n_fail++; $display("FAIL starve_streak_clear: got %0d want 0", dut.u_streak.streak_r); end
            end
            tick();                                     // back to IDLE
            m_ready = 1'b0; m_rvalid = 1'b0;
            if (k == 9) begin
                d_valid = 1'b0; i_valid = 1'b0;
            end
        end
        tick();
    endtask

    task automatic test_reset_in_resp();
        i_valid = 1'b1; i_addr = 32'hBFC0_0200;
        tick();
        i_valid = 1'b0; m_ready = 1'b1;
        tick();                                         // now RESP
        m_ready = 1'b0; #1;
        reset = 1'b1; #1;
        n_chk++; if (all_out !== 138'h0) begin n_fail++; $display("FAIL rst_resp_outputs: got %h want 0", all_out); end
        #1; reset = 1'b0;
        tick();
        m_rvalid = 1'b1; m_rdata = 32'h55AA_55AA; #1;
        n_chk++; if (all_out !== 138'h0) begin n_fail++; $display("FAIL rst_stale_rvalid: got %h want 0", all_out); end
        tick();
        m_rvalid = 1'b0;
        i_valid = 1'b1; i_addr = 32'hBFC0_0300;
        tick();
        i_valid = 1'b0; m_ready = 1'b1; #1;
        n_chk++; if (m_valid !== 1'b1 || m_addr !== 32'hBFC0_0300 || i_addr_ok !== 1'b1) begin
            n_fail++; $display("FAIL rst_next_req: got v=%b a=%h ok=%b want 1 bfc00300 1", m_valid, m_addr, i_addr_ok); end
        tick();
        m_ready = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h0BAD_F00D; #1;
        n_chk++; if (i_data_ok !== 1'b1 || i_rdata !== 32'h0BAD_F00D || d_data_ok !== 1'b0) begin
            n_fail++; $display("FAIL rst_next_data: got ok=%b rd=%h dok=%b want 1 0badf00d 0", i_data_ok, i_rdata, d_data_ok); end
        tick();
        clear_inputs(); #1;
        n_chk++; if (all_out !== 138'h0) begin n_fail++; $display("FAIL rst_next_idle: got %h want 0", all_out); end
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_simultaneous();
        test_stall();
        test_same_cycle();
        test_starvation();
        test_reset_in_resp();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
